// File: rtl/dot_product_seq.sv
// Sequential dot product: latches an N-element x/theta pair, accumulates LANES products per cycle.
// Optional DOT_SAT_EN clamps h to the DW-bit element range and adds sat_flag.
module dot_product_seq #(
    parameter int DW     = 8,
    parameter int N      = 8,
    parameter int LANES  = 2,
    parameter int SIGNED = 1,
    parameter int OUT_W  = 2*DW + $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*DW-1:0]   x,
    input  logic [N*DW-1:0]   theta,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  h,
    output logic              busy
`ifdef DOT_SAT_EN
    ,
    output logic              sat_flag
`endif
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid holds with stable data until then, ready never waits on valid.

    localparam int IW = $clog2(N + 1);
    localparam int PW = 2*DW + 2;
    localparam int SW = OUT_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state;
    logic [DW-1:0]       xa [N];
    logic [DW-1:0]       ta [N];
    logic [IW-1:0]       idx;
    logic [OUT_W-1:0]    acc;
    logic [OUT_W-1:0]    acc_next;
    logic [OUT_W-1:0]    h_next;
    logic signed [SW-1:0] lane_sum;
    logic signed [DW:0]  a_e;
    logic signed [DW:0]  b_e;
    logic signed [PW-1:0] prod;
    logic                last;
    logic                sat_hit;
    int                  k;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign last     = (int'(idx) + LANES == N);

    // One extra bit per operand lets a single signed multiplier serve both modes.
    always_comb begin
        lane_sum = '0;
        a_e      = '0;
        b_e      = '0;
        prod     = '0;
        k        = 0;
        for (int l = 0; l < LANES; l++) begin
            k        = int'(idx) + l;
            a_e      = {(SIGNED != 0) ? xa[k][DW-1] : 1'b0, xa[k]};
            b_e      = {(SIGNED != 0) ? ta[k][DW-1] : 1'b0, ta[k]};
            prod     = a_e * b_e;
            lane_sum = lane_sum + SW'(prod);
        end
        acc_next = acc + lane_sum[OUT_W-1:0];
    end

`ifdef DOT_SAT_EN
    localparam logic [OUT_W-1:0] SAT_HI = (SIGNED != 0) ? OUT_W'((1 << (DW-1)) - 1)
                                                        : OUT_W'((1 << DW) - 1);
    localparam logic [OUT_W-1:0] SAT_LO = (SIGNED != 0) ? OUT_W'(-(1 << (DW-1)))
                                                        : OUT_W'(0);

    always_comb begin
        sat_hit = 1'b0;
        h_next  = acc_next;
        if (SIGNED != 0) begin
            if ($signed(acc_next) > $signed(SAT_HI)) begin
                sat_hit = 1'b1;
                h_next  = SAT_HI;
            end else if ($signed(acc_next) < $signed(SAT_LO)) begin
                sat_hit = 1'b1;
                h_next  = SAT_LO;
            end
        end else if (acc_next > SAT_HI) begin
            sat_hit = 1'b1;
            h_next  = SAT_HI;
        end
    end
`else
    assign sat_hit = 1'b0;
    assign h_next  = acc_next;
`endif

    logic sat_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc       <= '0;
            idx       <= '0;
            h         <= '0;
            out_valid <= 1'b0;
            sat_q     <= 1'b0;
        end else if (clear) begin
            state     <= S_IDLE;
            acc       <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N; i++) begin
                            xa[i] <= x[(N-i)*DW-1 -: DW];
                            ta[i] <= theta[(N-i)*DW-1 -: DW];
                        end
                        acc   <= '0;
                        idx   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc <= acc_next;
                    if (last) begin
                        h         <= h_next;
                        out_valid <= 1'b1;
                        sat_q     <= sat_hit;
                        idx       <= '0;
                        state     <= S_DONE;
                    end else begin
                        idx <= idx + IW'(LANES);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        sat_q     <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DOT_SAT_EN
    assign sat_flag = sat_q;
`endif

endmodule
